// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings and burst FSM states.
package usr_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_HOLD      = 3'd0;
    localparam mode_t MODE_LOAD      = 3'd1;
    localparam mode_t MODE_LOAD_ONES = 3'd2;
    localparam mode_t MODE_CLEAR     = 3'd3;
    localparam mode_t MODE_SHL       = 3'd4;
    localparam mode_t MODE_SHR       = 3'd5;
    localparam mode_t MODE_ROL       = 3'd6;
    localparam mode_t MODE_ROR       = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Modes 4..7 move bits and are the only ones a burst may run.
    function automatic logic is_shift_mode(input mode_t mode);
        return mode[2];
    endfunction

endpackage

// File: rtl/usr_shift_step.sv
// One step of the universal register: next value and the bit pushed out, for any mode.
// USR_ASR_EN makes SHR arithmetic (MSB fill from the sign bit instead of ser_in).
module usr_shift_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  mode_t            mode,
    input  logic [WIDTH-1:0] data,
    input  logic             ser_in,
    output logic [WIDTH-1:0] next_data,
    output logic             shift_out
);

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        next_data = data;
        shift_out = 1'b0;
        case (mode)
            MODE_HOLD:      next_data = data;
            MODE_LOAD:      next_data = data;
            MODE_LOAD_ONES: next_data = '1;
            MODE_CLEAR:     next_data = '0;
            MODE_SHL: begin
                next_data = {data[WIDTH-2:0], ser_in};
                shift_out = data[WIDTH-1];
            end
            MODE_SHR: begin
`ifdef USR_ASR_EN
                next_data = {data[WIDTH-1], data[WIDTH-1:1]};
`else
                next_data = {ser_in, data[WIDTH-1:1]};
`endif
                shift_out = data[0];
            end
            MODE_ROL: begin
                next_data = {data[WIDTH-2:0], data[WIDTH-1]};
                shift_out = data[WIDTH-1];
            end
            MODE_ROR: begin
                next_data = {data[0], data[WIDTH-1:1]};
                shift_out = data[0];
            end
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal register with single-step operations and a counted shift/rotate burst engine.
// Build option USR_ASR_EN (handled in usr_shift_step) selects arithmetic SHR.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ser_in,
    input  logic             start,
    input  logic [CNT_W-1:0] shift_cnt,
    output logic [WIDTH-1:0] data_out,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mode_t            mode_q, mode_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ser_q, ser_d;
    logic             busy_q, done_q;

    mode_t            step_mode;
    logic [WIDTH-1:0] step_src;
    logic [WIDTH-1:0] step_data;
    logic             step_out;
    logic [CNT_W-1:0] cnt_sat;

    // LOAD takes data_in; every other mode transforms the current contents.
    assign step_mode = (state_q == ST_RUN) ? mode_q : mode;
    assign step_src  = (state_q != ST_RUN && mode == MODE_LOAD) ? data_in : data_q;
    assign cnt_sat   = (shift_cnt > CNT_MAX) ? CNT_MAX : shift_cnt;

    usr_shift_step #(.WIDTH(WIDTH)) u_step (
        .mode      (step_mode),
        .data      (step_src),
        .ser_in    (ser_in),
        .next_data (step_data),
        .shift_out (step_out)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        data_d  = data_q;
        ser_d   = ser_q;
        case (state_q)
            ST_IDLE: begin
                if (start && is_shift_mode(mode)) begin
                    mode_d  = mode;
                    cnt_d   = cnt_sat;
                    state_d = (cnt_sat == '0) ? ST_DONE : ST_RUN;
                end else if (enable || start) begin
                    data_d = step_data;
                    if (is_shift_mode(mode)) ser_d = step_out;
                end
            end
            ST_RUN: begin
                data_d = step_data;
                ser_d  = step_out;
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_HOLD;
            data_q  <= '0;
            ser_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            ser_q   <= ser_d;
            // Flopped from the next state so the handshake never glitches on state decode.
            busy_q  <= (state_d == ST_RUN);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign data_out = data_q;
    assign ser_out  = ser_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (WIDTH=8) with a queue scoreboard.
module tb_univ_shift_reg;
    import usr_pkg::*;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    mode_t         mode;
    logic [W-1:0]  data_in;
    logic          ser_in;
    logic          start;
    logic [CW-1:0] shift_cnt;
    logic [W-1:0]  data_out;
    logic          ser_out;
    logic          busy;
    logic          done;

    typedef struct {
        string        tag;
        logic [W-1:0] data;
        logic         ser;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    univ_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .mode      (mode),
        .data_in   (data_in),
        .ser_in    (ser_in),
        .start     (start),
        .shift_cnt (shift_cnt),
        .data_out  (data_out),
        .ser_out   (ser_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic st, input mode_t md,
                         input logic [W-1:0] din, input logic sin, input logic [CW-1:0] cnt);
        enable    = en;
        start     = st;
        mode      = md;
        data_in   = din;
        ser_in    = sin;
        shift_cnt = cnt;
    endtask

    task automatic expect_state(input string tag, input logic [W-1:0] d, input logic s,
                                input logic b, input logic dn);
        exp_t e;
        e.tag = tag; e.data = d; e.ser = s; e.busy = b; e.done = dn;
        sb.push_back(e);
    endtask

    // Clock one edge, then compare the oldest scoreboard entry against the DUT.
    task automatic tick_check();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_underflow", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({e.tag, ".data"}, 32'(data_out), 32'(e.data));
            check({e.tag, ".ser"},  32'(ser_out),  32'(e.ser));
            check({e.tag, ".busy"}, 32'(busy),     32'(e.busy));
            check({e.tag, ".done"}, 32'(done),     32'(e.done));
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".data"}, 32'(data_out), 32'h0);
        check({tag, ".ser"},  32'(ser_out),  32'h0);
        check({tag, ".busy"}, 32'(busy),     32'h0);
        check({tag, ".done"}, 32'(done),     32'h0);
    endtask

    logic [W-1:0] m_data;
    logic         m_ser;
    logic [W-1:0] shr1, shr2;

    initial begin
`ifdef USR_ASR_EN
        shr1 = 8'hC0; shr2 = 8'hE0;
`else
        shr1 = 8'h40; shr2 = 8'h20;
`endif
        rst_n = 1'b0;
        drive(1'b0, 1'b0, MODE_HOLD, 8'h00, 1'b0, '0);
        #22;
        check_reset_values("por");
        rst_n = 1'b1;

        // Make data and ser_out nonzero, then reset asynchronously mid-cycle.
        drive(1'b1, 1'b0, MODE_LOAD, 8'hFF, 1'b0, '0);
        expect_state("pre_load_ff", 8'hFF, 1'b0, 1'b0, 1'b0); tick_check();
        drive(1'b1, 1'b0, MODE_SHL, 8'h00, 1'b0, '0);
        expect_state("pre_shl", 8'hFE, 1'b1, 1'b0, 1'b0); tick_check();
        #4 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        #2 rst_n = 1'b1;

        drive(1'b1, 1'b0, MODE_LOAD, 8'hA5, 1'b0, '0);
        expect_state("load_a5", 8'hA5, 1'b0, 1'b0, 1'b0); tick_check();
        drive(1'b0, 1'b0, MODE_LOAD, 8'h3C, 1'b0, '0);
        expect_state("load_disabled", 8'hA5, 1'b0, 1'b0, 1'b0); tick_check();
        drive(1'b1, 1'b0, MODE_LOAD_ONES, 8'h00, 1'b0, '0);
        expect_state("load_ones", 8'hFF, 1'b0, 1'b0, 1'b0); tick_check();
        drive(1'b1, 1'b0, MODE_CLEAR, 8'h00, 1'b0, '0);
        expect_state("clear", 8'h00, 1'b0, 1'b0, 1'b0); tick_check();
        drive(1'b1, 1'b0, MODE_SHL, 8'h00, 1'b1, '0);
        expect_state("shl1", 8'h01, 1'b0, 1'b0, 1'b0); tick_check();
        expect_state("shl2", 8'h03, 1'b0, 1'b0, 1'b0); tick_check();
        expect_state("shl3", 8'h07, 1'b0, 1'b0, 1'b0); tick_check();

        // ROL burst of 3; a competing LOAD/start during RUN and DONE must be ignored.
        drive(1'b1, 1'b0, MODE_LOAD, 8'hA5, 1'b0, '0);
        expect_state("load_a5b", 8'hA5, 1'b0, 1'b0, 1'b0); tick_check();
        drive(1'b0, 1'b1, MODE_ROL, 8'h00, 1'b0, CW'(3));
        expect_state("rol_start", 8'hA5, 1'b0, 1'b1, 1'b0); tick_check();
        drive(1'b1, 1'b1, MODE_LOAD, 8'h00, 1'b0, CW'(1));
        expect_state("rol1", 8'h4B, 1'b1, 1'b1, 1'b0); tick_check();
        expect_state("rol2", 8'h96, 1'b0, 1'b1, 1'b0); tick_check();
        expect_state("rol3", 8'h2D, 1'b1, 1'b0, 1'b1); tick_check();
        expect_state("rol_done_gap", 8'h2D, 1'b1, 1'b0, 1'b0); tick_check();

        // SHR burst of 2 with ser_in=0 (arithmetic variant under USR_ASR_EN).
        drive(1'b1, 1'b0, MODE_LOAD, 8'h80, 1'b0, '0);
        expect_state("load_80", 8'h80, 1'b1, 1'b0, 1'b0); tick_check();
        drive(1'b0, 1'b1, MODE_SHR, 8'h00, 1'b0, CW'(2));
        expect_state("shr_start", 8'h80, 1'b1, 1'b1, 1'b0); tick_check();
        drive(1'b0, 1'b0, MODE_HOLD, 8'h00, 1'b0, '0);
        expect_state("shr1", shr1, 1'b0, 1'b1, 1'b0); tick_check();
        expect_state("shr2", shr2, 1'b0, 1'b0, 1'b1); tick_check();
        expect_state("shr_idle", shr2, 1'b0, 1'b0, 1'b0); tick_check();

        // Zero-length burst: done only, no busy, data unchanged.
        drive(1'b0, 1'b1, MODE_SHL, 8'h00, 1'b1, '0);
        expect_state("cnt0_start", shr2, 1'b0, 1'b0, 1'b1); tick_check();
        drive(1'b0, 1'b0, MODE_HOLD, 8'h00, 1'b0, '0);
        expect_state("cnt0_after", shr2, 1'b0, 1'b0, 1'b0); tick_check();

        // Count above WIDTH saturates: ROR by 8 returns to the start value.
        drive(1'b1, 1'b0, MODE_LOAD, 8'hA5, 1'b0, '0);
        expect_state("load_a5c", 8'hA5, 1'b0, 1'b0, 1'b0); tick_check();
        drive(1'b0, 1'b1, MODE_ROR, 8'h00, 1'b0, '1);
        expect_state("ror_sat_start", 8'hA5, 1'b0, 1'b1, 1'b0); tick_check();
        drive(1'b0, 1'b0, MODE_HOLD, 8'h00, 1'b0, '0);
        m_data = 8'hA5;
        m_ser  = 1'b0;
        for (int i = 1; i <= W; i++) begin
            m_ser  = m_data[0];
            m_data = {m_data[0], m_data[W-1:1]};
            expect_state($sformatf("ror_sat%0d", i), m_data, m_ser, (i < W), (i == W));
            tick_check();
        end
        expect_state("ror_sat_idle", 8'hA5, m_ser, 1'b0, 1'b0); tick_check();

        // start with a non-shift mode acts as a single-step enable.
        drive(1'b0, 1'b1, MODE_LOAD, 8'h3C, 1'b0, '0);
        expect_state("start_as_enable", 8'h3C, m_ser, 1'b0, 1'b0); tick_check();

        // SHL burst samples ser_in live on each shift edge.
        drive(1'b0, 1'b1, MODE_SHL, 8'h00, 1'b0, CW'(2));
        expect_state("shl_burst_start", 8'h3C, m_ser, 1'b1, 1'b0); tick_check();
        drive(1'b0, 1'b0, MODE_HOLD, 8'h00, 1'b1, '0);
        expect_state("shl_burst1", 8'h79, 1'b0, 1'b1, 1'b0); tick_check();
        ser_in = 1'b0;
        expect_state("shl_burst2", 8'hF2, 1'b0, 1'b0, 1'b1); tick_check();
        expect_state("shl_burst_idle", 8'hF2, 1'b0, 1'b0, 1'b0); tick_check();

        // Reset in the middle of a ROL burst of 5 aborts with no done pulse.
        drive(1'b0, 1'b1, MODE_ROL, 8'h00, 1'b0, CW'(5));
        expect_state("abort_start", 8'hF2, 1'b0, 1'b1, 1'b0); tick_check();
        drive(1'b0, 1'b0, MODE_HOLD, 8'h00, 1'b0, '0);
        expect_state("abort_rol1", 8'hE5, 1'b1, 1'b1, 1'b0); tick_check();
        expect_state("abort_rol2", 8'hCB, 1'b1, 1'b1, 1'b0); tick_check();
        #3 rst_n = 1'b0;
        #1 check_reset_values("mid_burst_reset");
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_state($sformatf("post_abort%0d", i), 8'h00, 1'b0, 1'b0, 1'b0);
            tick_check();
        end

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
